// File: rtl/soc_bus_fabric.sv
// Address decoder, read-data mux and wait-state controller between a FemtoRV32 core
// and N_SLAVES memory-mapped slaves, with per-slave ready, bus timeout and error capture.
module soc_bus_fabric #(
   parameter int          N_SLAVES     = 7,
   parameter logic [15:0] PER_BASE     = 16'h0040,
   parameter logic [15:0] RAM_PAGE     = 16'h0000,
   parameter bit          UNMAP_TO_RAM = 1'b1,
   parameter int          TIMEOUT      = 255,
   parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [31:0]             cpu_addr,
   input  logic                    cpu_rstrb,
   input  logic [3:0]              cpu_wmask,
   output logic [31:0]             cpu_rdata,
   output logic                    cpu_rbusy,
   output logic                    cpu_wbusy,
   output logic [N_SLAVES-1:0]     sl_cs,
   output logic                    sl_rd,
   output logic                    sl_wr,
   input  logic [32*N_SLAVES-1:0]  sl_rdata,
   input  logic [N_SLAVES-1:0]     sl_ready,
   input  logic                    err_clr,
   output logic                    err_flag,
   output logic [31:0]             err_addr
);

   localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic [IW-1:0]  dec_idx;
   logic           dec_hit;
   logic           dec_unmapped;
   logic [IW-1:0]  sel_q;
   logic           unmap_q;
   logic [7:0]     count;
   logic           sel_ready;
   logic [31:0]    sel_rdata;
   logic           done;
   logic           timed_out;
   logic           accept_rd;
   logic           accept_wr;
   logic           err_set;

   // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      dec_idx = '0;
      dec_hit = 1'b0;
      if (cpu_addr[31:16] == RAM_PAGE) begin
         dec_hit = 1'b1;
      end else begin
         for (int k = 1; k < N_SLAVES; k++) begin
            if (cpu_addr[31:16] == PER_BASE + 16'(k - 1)) begin
               dec_hit = 1'b1;
               dec_idx = IW'(k);
            end
         end
      end
      dec_unmapped = !dec_hit && !UNMAP_TO_RAM;
      for (int k = 0; k < N_SLAVES; k++) begin
         sl_cs[k] = !dec_unmapped && (dec_idx == IW'(k));
      end
   end

   // Ready and data of the slave latched at request accept.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (sel_q == IW'(k)) begin
            sel_ready = sl_ready[k];
            sel_rdata = sl_rdata[32*k +: 32];
         end
      end
   end

   // An unmapped access never reaches a slave, so it completes as if ready were tied high.
   assign done      = unmap_q || sel_ready;
   assign timed_out = !done && (count == 8'(TIMEOUT - 1));
   assign accept_wr = resetn && (state == IDLE) && (cpu_wmask != 4'd0);
   assign accept_rd = resetn && (state == IDLE) && cpu_rstrb && (cpu_wmask == 4'd0);
   assign err_set   = (state != IDLE) && (timed_out || unmap_q);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept_wr) begin
               state_nxt = WR_WAIT;
            end else if (accept_rd) begin
               state_nxt = RD_WAIT;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (done || timed_out) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cpu_rbusy = (state == RD_WAIT);
      cpu_wbusy = (state == WR_WAIT);
      sl_rd     = accept_rd && !dec_unmapped;
      sl_wr     = accept_wr && !dec_unmapped;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cpu_rdata <= '0;
         count     <= '0;
         sel_q     <= '0;
         unmap_q   <= 1'b0;
         err_flag  <= 1'b0;
         err_addr  <= '0;
      end else begin
         if (state == IDLE) begin
            count <= '0;
            if (accept_wr || accept_rd) begin
               sel_q   <= dec_idx;
               unmap_q <= dec_unmapped;
            end
         end else if (done || timed_out) begin
            count <= '0;
         end else begin
            count <= count + 8'd1;
         end

         if (state == RD_WAIT) begin
            if (done) begin
               cpu_rdata <= unmap_q ? ERR_DATA : sel_rdata;
            end else if (timed_out) begin
               cpu_rdata <= ERR_DATA;
            end
         end

         // A new error beats a simultaneous clear; the first error address is kept until cleared.
         if (err_set) begin
            err_flag <= 1'b1;
            if (!err_flag || err_clr) begin
               err_addr <= cpu_addr;
            end
         end else if (err_clr) begin
            err_flag <= 1'b0;
            err_addr <= '0;
         end
      end
   end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Scoreboard bench for soc_bus_fabric: directed requests push expected completions,
// a negedge monitor pops and compares them whenever a busy phase ends.
module tb_soc_bus_fabric;

   localparam int N = 7;

   typedef struct {
      bit          is_read;
      logic [31:0] rdata;
      int          cycles;
      logic        err;
      logic [31:0] eaddr;
   } exp_t;

   logic            clk;
   logic            resetn;
   logic [31:0]     cpu_addr;
   logic            cpu_rstrb;
   logic [3:0]      cpu_wmask;
   logic [31:0]     cpu_rdata;
   logic            cpu_rbusy;
   logic            cpu_wbusy;
   logic [N-1:0]    sl_cs;
   logic            sl_rd;
   logic            sl_wr;
   logic [32*N-1:0] sl_rdata;
   logic [N-1:0]    sl_ready;
   logic            err_clr;
   logic            err_flag;
   logic [31:0]     err_addr;

   logic [31:0]     rdata_b;
   logic            rbusy_b;
   logic            wbusy_b;
   logic [N-1:0]    cs_b;
   logic            rd_b;
   logic            wr_b;
   logic            eflag_b;
   logic [31:0]     eaddr_b;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   soc_bus_fabric #(.N_SLAVES(N), .UNMAP_TO_RAM(1'b0)) dut (
      .clk(clk), .resetn(resetn), .cpu_addr(cpu_addr), .cpu_rstrb(cpu_rstrb),
      .cpu_wmask(cpu_wmask), .cpu_rdata(cpu_rdata), .cpu_rbusy(cpu_rbusy),
      .cpu_wbusy(cpu_wbusy), .sl_cs(sl_cs), .sl_rd(sl_rd), .sl_wr(sl_wr),
      .sl_rdata(sl_rdata), .sl_ready(sl_ready), .err_clr(err_clr),
      .err_flag(err_flag), .err_addr(err_addr)
   );

   // Second instance with unmapped pages folded onto RAM; only its decode is checked.
   soc_bus_fabric #(.N_SLAVES(N), .UNMAP_TO_RAM(1'b1)) dut_ram (
      .clk(clk), .resetn(resetn), .cpu_addr(cpu_addr), .cpu_rstrb(cpu_rstrb),
      .cpu_wmask(cpu_wmask), .cpu_rdata(rdata_b), .cpu_rbusy(rbusy_b),
      .cpu_wbusy(wbusy_b), .sl_cs(cs_b), .sl_rd(rd_b), .sl_wr(wr_b),
      .sl_rdata(sl_rdata), .sl_ready(sl_ready), .err_clr(err_clr),
      .err_flag(eflag_b), .err_addr(eaddr_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input bit is_read, input logic [31:0] rdata, input int cycles,
                               input logic err, input logic [31:0] eaddr);
      exp_t e;
      e.is_read = is_read;
      e.rdata   = rdata;
      e.cycles  = cycles;
      e.err     = err;
      e.eaddr   = eaddr;
      return e;
   endfunction

   // Presents a request for cycle T, checks the same-cycle strobes, queues the completion.
   task automatic issue(input logic [31:0] addr, input logic rstrb, input logic [3:0] wmask,
                        input logic exp_rd, input logic exp_wr, input logic [N-1:0] exp_cs,
                        input exp_t e);
      @(posedge clk);
      #1;
      cpu_addr  = addr;
      cpu_rstrb = rstrb;
      cpu_wmask = wmask;
      @(negedge clk);
      check("sl_rd", {31'd0, sl_rd}, {31'd0, exp_rd});
      check("sl_wr", {31'd0, sl_wr}, {31'd0, exp_wr});
      check("sl_cs", {25'd0, sl_cs}, {25'd0, exp_cs});
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      cpu_rstrb = 1'b0;
      cpu_wmask = 4'd0;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((cpu_rbusy || cpu_wbusy) && n < max_cycles);
      check("wait_idle", {30'd0, cpu_rbusy, cpu_wbusy}, 32'd0);
   endtask

   task automatic pulse_clr();
      @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      @(negedge clk);
      check("clr_flag", {31'd0, err_flag}, 32'd0);
      check("clr_addr", err_addr, 32'd0);
   endtask

   initial begin : monitor
      bit   prev_r;
      bit   prev_w;
      int   busy_cnt;
      exp_t e;
      prev_r   = 1'b0;
      prev_w   = 1'b0;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (cpu_rbusy === 1'b1 || cpu_wbusy === 1'b1) begin
            busy_cnt++;
         end else if (prev_r || prev_w) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underflow: got completion expected none at %0t", $time);
            end else begin
               e = sb_q.pop_front();
               check("mon_kind", {31'd0, prev_r}, {31'd0, e.is_read});
               check("mon_rdata", cpu_rdata, e.rdata);
               check("mon_cycles", busy_cnt, e.cycles);
               check("mon_err_flag", {31'd0, err_flag}, {31'd0, e.err});
               check("mon_err_addr", err_addr, e.eaddr);
            end
            busy_cnt = 0;
         end
         prev_r = (cpu_rbusy === 1'b1);
         prev_w = (cpu_wbusy === 1'b1);
      end
   end

   initial begin
      resetn    = 1'b0;
      cpu_addr  = '0;
      cpu_rstrb = 1'b0;
      cpu_wmask = 4'd0;
      err_clr   = 1'b0;
      sl_ready  = '1;
      sl_rdata  = '0;
      sl_rdata[32*0 +: 32] = 32'h12345678;
      sl_rdata[32*2 +: 32] = 32'h22220002;
      sl_rdata[32*3 +: 32] = 32'h33330003;
      sl_rdata[32*6 +: 32] = 32'h66660006;

      repeat (3) @(negedge clk);
      check("rst_rdata", cpu_rdata, 32'd0);
      check("rst_rbusy", {31'd0, cpu_rbusy}, 32'd0);
      check("rst_wbusy", {31'd0, cpu_wbusy}, 32'd0);
      check("rst_sl_rd", {31'd0, sl_rd}, 32'd0);
      check("rst_sl_wr", {31'd0, sl_wr}, 32'd0);
      check("rst_err_flag", {31'd0, err_flag}, 32'd0);
      check("rst_err_addr", err_addr, 32'd0);
      @(posedge clk);
      #1 resetn = 1'b1;

      // RAM read, 1-cycle slave
      issue(32'h00000010, 1'b1, 4'h0, 1'b1, 1'b0, 7'b0000001, mk(1'b1, 32'h12345678, 1, 1'b0, 32'd0));
      wait_idle(10);

      // Last peripheral page (slave 6)
      issue(32'h00450008, 1'b1, 4'h0, 1'b1, 1'b0, 7'b1000000, mk(1'b1, 32'h66660006, 1, 1'b0, 32'd0));
      wait_idle(10);

      // Write to slave 3, ready on the 4th wait cycle; a read strobe while busy is ignored
      sl_ready = 7'b1110111;
      issue(32'h00420004, 1'b0, 4'hF, 1'b0, 1'b1, 7'b0001000, mk(1'b0, 32'h66660006, 4, 1'b0, 32'd0));
      cpu_rstrb = 1'b1;
      @(negedge clk);
      check("busy_rd_ignored", {31'd0, sl_rd}, 32'd0);
      check("busy_wr_ignored", {31'd0, sl_wr}, 32'd0);
      @(posedge clk);
      #1 cpu_rstrb = 1'b0;
      repeat (2) @(posedge clk);
      #1 sl_ready[3] = 1'b1;
      wait_idle(10);

      // Timeout on slave 2
      sl_ready = 7'b1111011;
      issue(32'h00410000, 1'b1, 4'h0, 1'b1, 1'b0, 7'b0000100, mk(1'b1, 32'hDEADBEEF, 255, 1'b1, 32'h00410000));
      wait_idle(300);
      sl_ready = '1;
      pulse_clr();

      // Unmapped read, then unmapped write keeps the first error address
      issue(32'h00990000, 1'b1, 4'h0, 1'b0, 1'b0, 7'b0000000, mk(1'b1, 32'hDEADBEEF, 1, 1'b1, 32'h00990000));
      check("ram_fold_cs", {25'd0, cs_b}, 32'd1);
      wait_idle(10);
      issue(32'h00980000, 1'b0, 4'h1, 1'b0, 1'b0, 7'b0000000, mk(1'b0, 32'hDEADBEEF, 1, 1'b1, 32'h00990000));
      wait_idle(10);

      // Page just past the last peripheral; err_clr coincides with the new error
      issue(32'h00460000, 1'b1, 4'h0, 1'b0, 1'b0, 7'b0000000, mk(1'b1, 32'hDEADBEEF, 1, 1'b1, 32'h00460000));
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      wait_idle(10);
      pulse_clr();

      // Reset in the middle of a stalled read aborts it
      sl_ready = 7'b1111011;
      issue(32'h00410000, 1'b1, 4'h0, 1'b1, 1'b0, 7'b0000100, mk(1'b1, 32'd0, 5, 1'b0, 32'd0));
      repeat (4) @(posedge clk);
      #1 resetn = 1'b0;
      @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      check("abort_rbusy", {31'd0, cpu_rbusy}, 32'd0);
      sl_ready = '1;

      issue(32'h00000010, 1'b1, 4'h0, 1'b1, 1'b0, 7'b0000001, mk(1'b1, 32'h12345678, 1, 1'b0, 32'd0));
      wait_idle(10);

      // Read and write strobes together: only the write goes out
      issue(32'h00400000, 1'b1, 4'h3, 1'b0, 1'b1, 7'b0000010, mk(1'b0, 32'h12345678, 1, 1'b0, 32'd0));
      wait_idle(10);

      repeat (3) @(negedge clk);
      check("sb_empty", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
